dmem_ctrl: RTL and testbench

//  Parametrised data-memory block for the MA stage; successor to the fixed single-cycle data memory.

---
 rtl/dmem_ctrl.sv | 154 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Data memory for the MA stage: byte/half/word access, wait states, req/busy/valid handshake.
// Define DMEM_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors.
module dmem_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h10010000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT        = 0,
  parameter logic [31:0] INIT_WORD   = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [1:0]  width,
  input  logic        uns,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        valid,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int unsigned AW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WaitM1 = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, uns_q;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  width_q;

  logic        accept, do_access;
  logic        a_we, a_uns;
  logic [31:0] a_addr, a_wdata;
  logic [1:0]  a_width;
  logic [31:0] off;
  logic [29:0] idx_full;
  logic [AW-1:0] idx;
  logic        range_err, width_err, mis_err, acc_err;
  logic [31:0] cur, new_w, load_val;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  logic [31:0] mem [DEPTH_WORDS] = '{default: INIT_WORD};

  assign busy  = (state_q == StWait);
  assign valid = (state_q == StDone);

  always_comb begin
    accept  = req && (state_q == StIdle || state_q == StDone);
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StWait: begin
        if (cnt_q == 4'd0) state_d = StDone;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: begin
        if (accept) begin
          if (WAIT == 0) begin
            state_d = StDone;
          end else begin
            state_d = StWait;
            cnt_d   = WaitM1;
          end
        end else begin
          state_d = StIdle;
        end
      end
    endcase
    // Entering DONE always means a fresh access completes on this edge.
    do_access = !rst && (state_d == StDone);
  end

  // With no wait states the access happens on the accept edge, so use live inputs.
  always_comb begin
    if (WAIT == 0) begin
      a_we = we;   a_addr = addr;   a_width = width;   a_uns = uns;   a_wdata = wdata;
    end else begin
      a_we = we_q; a_addr = addr_q; a_width = width_q; a_uns = uns_q; a_wdata = wdata_q;
    end
  end

  always_comb begin
    off       = a_addr - BASE_ADDR;
    idx_full  = off[31:2];
    idx       = idx_full[AW-1:0];
    range_err = (idx_full >= 30'(DEPTH_WORDS));
    width_err = (a_width == 2'b11);
`ifdef DMEM_MISALIGN_TRAP_EN
    mis_err   = (a_width == 2'b01 && off[0]) || (a_width == 2'b10 && off[1:0] != 2'b00);
`else
    mis_err   = 1'b0;
`endif
    acc_err   = range_err | width_err | mis_err;
    cur       = mem[idx];
    byte_v    = cur[{off[1:0], 3'b000} +: 8];
    half_v    = off[1] ? cur[31:16] : cur[15:0];

    load_val = cur;
    new_w    = cur;
    unique case (a_width)
      2'b00: begin
        load_val = a_uns ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
        new_w[{off[1:0], 3'b000} +: 8] = a_wdata[7:0];
      end
      2'b01: begin
        load_val = a_uns ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
        if (off[1]) new_w[31:16] = a_wdata[15:0];
        else        new_w[15:0]  = a_wdata[15:0];
      end
      default: begin
        load_val = cur;
        new_w    = a_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      width_q <= 2'b00;
      uns_q   <= 1'b0;
      wdata_q <= 32'd0;
      rdata   <= 32'd0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= we;
        addr_q  <= addr;
        width_q <= width;
        uns_q   <= uns;
        wdata_q <= wdata;
      end
      if (do_access) begin
        err   <= acc_err;
        rdata <= (acc_err || a_we) ? 32'd0 : load_val;
      end
    end
  end

  // Contents survive reset, so the array sits outside the reset branch.
  always_ff @(posedge clk) begin
    if (do_access && a_we && !acc_err) mem[idx] <= new_w;
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: three instances (WAIT=0, 3, 2) sharing access inputs.
module tb_dmem_ctrl;

  localparam logic [31:0] BASE = 32'h10010000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst3, rst2, req0, req3, req2;
  logic        we, uns;
  logic [31:0] addr, wdata;
  logic [1:0]  width;
  logic        busy0, valid0, err0, busy3, valid3, err3, busy2, valid2, err2;
  logic [31:0] rdata0, rdata3, rdata2;

  dmem_ctrl #(.WAIT(0)) dut0 (
    .clk(clk), .rst(rst0), .req(req0), .we(we), .addr(addr), .width(width), .uns(uns),
    .wdata(wdata), .busy(busy0), .valid(valid0), .rdata(rdata0), .err(err0)
  );
  dmem_ctrl #(.WAIT(3)) dut3 (
    .clk(clk), .rst(rst3), .req(req3), .we(we), .addr(addr), .width(width), .uns(uns),
    .wdata(wdata), .busy(busy3), .valid(valid3), .rdata(rdata3), .err(err3)
  );
  dmem_ctrl #(.WAIT(2)) dut2 (
    .clk(clk), .rst(rst2), .req(req2), .we(we), .addr(addr), .width(width), .uns(uns),
    .wdata(wdata), .busy(busy2), .valid(valid2), .rdata(rdata2), .err(err2)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          id;
  } exp_t;

  exp_t q0[$], q3[$], q2[$];
  int   n_cmp = 0, n_bad = 0, next_id = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp_v);
    end
  endfunction

  // Monitors: pop one expectation per valid pulse.
  always @(negedge clk) begin
    exp_t x;
    if (valid0 === 1'b1) begin
      if (q0.size() == 0) check("dut0 unexpected valid", 32'd1, 32'd0);
      else begin
        x = q0.pop_front();
        check($sformatf("dut0 rdata #%0d", x.id), rdata0, x.rdata);
        check($sformatf("dut0 err #%0d", x.id), {31'b0, err0}, {31'b0, x.err});
      end
    end
  end
  always @(negedge clk) begin
    exp_t x;
    if (valid3 === 1'b1) begin
      if (q3.size() == 0) check("dut3 unexpected valid", 32'd1, 32'd0);
      else begin
        x = q3.pop_front();
        check($sformatf("dut3 rdata #%0d", x.id), rdata3, x.rdata);
        check($sformatf("dut3 err #%0d", x.id), {31'b0, err3}, {31'b0, x.err});
      end
    end
  end
  always @(negedge clk) begin
    exp_t x;
    if (valid2 === 1'b1) begin
      if (q2.size() == 0) check("dut2 unexpected valid", 32'd1, 32'd0);
      else begin
        x = q2.pop_front();
        check($sformatf("dut2 rdata #%0d", x.id), rdata2, x.rdata);
        check($sformatf("dut2 err #%0d", x.id), {31'b0, err2}, {31'b0, x.err});
      end
    end
  end

  task automatic go0(input logic w, input logic [31:0] a, input logic [1:0] wd, input logic u,
                     input logic [31:0] d, input logic [31:0] er, input logic ee);
    we = w; addr = a; width = wd; uns = u; wdata = d; req0 = 1'b1;
    q0.push_back(exp_t'{er, ee, next_id});
    next_id++;
    @(posedge clk); #1;
    req0 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] hold_rd;
    logic        hold_err;
    rst0 = 1'b1; rst3 = 1'b1; rst2 = 1'b1;
    req0 = 1'b0; req3 = 1'b0; req2 = 1'b0;
    we = 1'b0; addr = 32'd0; width = 2'b00; uns = 1'b0; wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst0 = 1'b0; rst3 = 1'b0; rst2 = 1'b0;
    @(negedge clk);
    check("reset busy0", {31'b0, busy0}, 32'd0);
    check("reset valid0", {31'b0, valid0}, 32'd0);
    check("reset err0", {31'b0, err0}, 32'd0);
    check("reset rdata0", rdata0, 32'd0);
    check("reset busy3", {31'b0, busy3}, 32'd0);
    @(posedge clk); #1;

    // Back-to-back accesses, WAIT=0
    go0(1, BASE,       2'b10, 0, 32'hDEADBEEF, 32'h0,        0);
    go0(0, BASE,       2'b10, 0, 32'h0,        32'hDEADBEEF, 0);
    go0(1, BASE + 4,   2'b10, 0, 32'h11223344, 32'h0,        0);
    go0(1, BASE + 5,   2'b00, 0, 32'hABCDEF80, 32'h0,        0);
    go0(0, BASE + 5,   2'b00, 0, 32'h0,        32'hFFFFFF80, 0);
    go0(0, BASE + 5,   2'b00, 1, 32'h0,        32'h00000080, 0);
    go0(0, BASE + 4,   2'b10, 0, 32'h0,        32'h11228044, 0);
    go0(0, BASE + 4,   2'b01, 0, 32'h0,        32'hFFFF8044, 0);
    go0(0, BASE + 6,   2'b01, 1, 32'h0,        32'h00001122, 0);
    go0(1, BASE + 6,   2'b01, 0, 32'h1234BEEF, 32'h0,        0);
    go0(0, BASE + 4,   2'b10, 1, 32'h0,        32'hBEEF8044, 0);
    go0(0, BASE + 7,   2'b00, 0, 32'h0,        32'hFFFFFFBE, 0);
    // Range, reserved width
    go0(0, 32'h1000FFFC,       2'b10, 0, 32'h0,        32'h0,        1);
    go0(0, BASE + 32'h1000,    2'b10, 0, 32'h0,        32'h0,        1);
    go0(1, BASE + 32'h1000,    2'b10, 0, 32'h55555555, 32'h0,        1);
    go0(0, BASE,               2'b10, 0, 32'h0,        32'hDEADBEEF, 0);
    go0(1, BASE + 32'hFFC,     2'b10, 0, 32'hA5A5A5A5, 32'h0,        0);
    go0(0, BASE + 32'hFFC,     2'b10, 0, 32'h0,        32'hA5A5A5A5, 0);
    go0(0, BASE,               2'b11, 0, 32'h0,        32'h0,        1);
    go0(1, BASE,               2'b11, 0, 32'hFFFFFFFF, 32'h0,        1);
    go0(0, BASE,               2'b10, 0, 32'h0,        32'hDEADBEEF, 0);
    // Misaligned
`ifdef DMEM_MISALIGN_TRAP_EN
    go0(0, BASE + 3, 2'b01, 0, 32'h0, 32'h0, 1);
    go0(0, BASE + 2, 2'b10, 0, 32'h0, 32'h0, 1);
    hold_rd = 32'h0; hold_err = 1'b1;
`else
    go0(0, BASE + 3, 2'b01, 0, 32'h0, 32'hFFFFDEAD, 0);
    go0(0, BASE + 2, 2'b10, 0, 32'h0, 32'hDEADBEEF, 0);
    hold_rd = 32'hDEADBEEF; hold_err = 1'b0;
`endif
    addr = 32'h0; width = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("dut0 rdata held", rdata0, hold_rd);
    check("dut0 err held", {31'b0, err0}, {31'b0, hold_err});
    check("dut0 valid idle", {31'b0, valid0}, 32'd0);

    // WAIT=3 timing, input changes ignored while busy, held req accepted in DONE
    @(posedge clk); #1;
    we = 1; addr = BASE + 16; width = 2'b10; uns = 0; wdata = 32'h12345678; req3 = 1'b1;
    q3.push_back(exp_t'{32'h0, 1'b0, next_id});
    next_id++;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      case (k)
        1, 2: begin
          we = 0; addr = BASE + 20; wdata = 32'hFFFFFFFF; width = 2'b11; req3 = (k == 2);
        end
        3: begin
          we = 0; addr = BASE + 16; width = 2'b10; req3 = 1'b1;
          q3.push_back(exp_t'{32'h12345678, 1'b0, next_id});
          next_id++;
        end
        5: req3 = 1'b0;
        default: ;
      endcase
      @(negedge clk);
      check($sformatf("dut3 busy cycle %0d", k), {31'b0, busy3},
            {31'b0, (k inside {[1:3], [5:7]})});
      check($sformatf("dut3 valid cycle %0d", k), {31'b0, valid3},
            {31'b0, (k == 4 || k == 8)});
    end
    @(posedge clk); #1;
    we = 0; addr = BASE + 20; width = 2'b10; req3 = 1'b1;
    q3.push_back(exp_t'{32'h0, 1'b0, next_id});
    next_id++;
    @(posedge clk); #1;
    req3 = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // WAIT=2: reset during a store drops it
    we = 1; addr = BASE + 32; width = 2'b10; wdata = 32'hAAAA5555; req2 = 1'b1;
    q2.push_back(exp_t'{32'h0, 1'b0, next_id});
    next_id++;
    @(posedge clk); #1;
    req2 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    we = 1; addr = BASE + 32; wdata = 32'h11111111; req2 = 1'b1;
    @(posedge clk); #1;
    req2 = 1'b0; rst2 = 1'b1;
    @(posedge clk); #1;
    rst2 = 1'b0;
    @(negedge clk);
    check("dut2 busy after reset", {31'b0, busy2}, 32'd0);
    check("dut2 valid after reset", {31'b0, valid2}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    we = 0; addr = BASE + 32; width = 2'b10; req2 = 1'b1;
    q2.push_back(exp_t'{32'hAAAA5555, 1'b0, next_id});
    next_id++;
    @(posedge clk); #1;
    req2 = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);

    check("dut0 pending expectations", q0.size(), 32'd0);
    check("dut3 pending expectations", q3.size(), 32'd0);
    check("dut2 pending expectations", q2.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
